// File: rtl/pid_output_limiter_pkg.sv
// ----------------------------------------------------------------------------
// pid_output_limiter_pkg
// Shared definitions for the PID output limiter:
//   - FSM state encodings (IDLE, RUN, FLUSH)
//   - float_key(): maps an IEEE-754 single onto an unsigned-ordered key
//   - is_nan():    NaN detect (exponent all ones, mantissa nonzero)
// `SINGLE and `N_WindTurbine normally come from global_parameter.v; the
// fallbacks below only apply when that file is not part of the build.
// ----------------------------------------------------------------------------
`ifndef SINGLE
`define SINGLE 32
`endif
`ifndef N_WindTurbine
`define N_WindTurbine 4
`endif

package pid_output_limiter_pkg;

    localparam int FW = `SINGLE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Negative floats order in reverse magnitude, so they are inverted;
    // positive floats get the top bit set so they rank above all negatives.
    function automatic logic [FW-1:0] float_key(input logic [FW-1:0] bits);
        return bits[FW-1] ? ~bits : (bits | {1'b1, {(FW-1){1'b0}}});
    endfunction

    function automatic logic is_nan(input logic [FW-1:0] bits);
        return (bits[30:23] == 8'hFF) && (bits[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/float_order_key.sv
// ----------------------------------------------------------------------------
// float_order_key
// Combinational 32-bit order key for an IEEE-754 single, so that unsigned
// compares of keys match numeric order of the floats.
// Ports:
//   bits  in   FW  float input
//   key   out  FW  ordered key
// ----------------------------------------------------------------------------
module float_order_key
    import pid_output_limiter_pkg::*;
(
    input  logic [FW-1:0] bits,
    output logic [FW-1:0] key
);

    assign key = float_key(bits);

endmodule

// File: rtl/pid_output_limiter.sv
// ----------------------------------------------------------------------------
// pid_output_limiter
// Frames N_CH PID output samples, clamps each to [YMIN, YMAX] using ordered
// float keys, and emits them two cycles later with their channel index.
// NaN samples become +0.0 and raise frame_err. Protocol errors (stray
// valid_in, sta mid-frame) also raise frame_err.
//
// Optional feature: define PID_LIMIT_STATUS_EN to keep a per-channel
// saturation bitmap on sat_flags; otherwise sat_flags is tied to 0.
//
// Ports:
//   clk        in   1      clock
//   rst_user   in   1      async active-high reset
//   sta        in   1      frame-start strobe, one cycle
//   valid_in   in   1      y_in valid
//   y_in       in   32     PID output sample, single float
//   y_out      out  32     clamped sample
//   valid_out  out  1      y_out valid
//   chan_out   out  CW     channel index of y_out
//   done_sig   out  1      one-cycle end-of-frame pulse
//   frame_err  out  1      one-cycle protocol/NaN error pulse
//   sat_flags  out  N_CH   per-channel saturation bitmap
// ----------------------------------------------------------------------------
`ifndef N_WindTurbine
`define N_WindTurbine 4
`endif

module pid_output_limiter
    import pid_output_limiter_pkg::*;
#(
    parameter int          N_CH = `N_WindTurbine,
    parameter logic [31:0] YMAX = 32'h3F800000,
    parameter logic [31:0] YMIN = 32'hBF800000,
    localparam int         CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_user,
    input  logic            sta,
    input  logic            valid_in,
    input  logic [31:0]     y_in,
    output logic [31:0]     y_out,
    output logic            valid_out,
    output logic [CW-1:0]   chan_out,
    output logic            done_sig,
    output logic            frame_err,
    output logic [N_CH-1:0] sat_flags
);

    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
    // Clamp limits are constants, so their keys are folded at elaboration.
    localparam logic [31:0]   KMAX = float_key(YMAX);
    localparam logic [31:0]   KMIN = float_key(YMIN);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic          accept, last, abort, proto_err;

    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    // A cycle carrying sta never accepts a sample, whatever the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        accept    = 1'b0;
        last      = 1'b0;
        abort     = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (sta) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    proto_err = valid_in;
                end else if (valid_in) begin
                    proto_err = 1'b1;
                end
            end
            RUN: begin
                if (sta) begin
                    abort     = 1'b1;
                    proto_err = 1'b1;
                    cnt_d     = '0;
                end else if (valid_in) begin
                    accept = 1'b1;
                    if (cnt_q == LAST) begin
                        // Counter parks on the last channel; no wrap.
                        last    = 1'b1;
                        state_d = FLUSH;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (sta) begin
                    abort     = 1'b1;
                    proto_err = 1'b1;
                    state_d   = RUN;
                    cnt_d     = '0;
                end else begin
                    proto_err = valid_in;
                    flush_d   = 1'b1;
                    if (flush_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Two-stage datapath: stage 1 captures, stage 2 clamps and drives out
    // ------------------------------------------------------------------
    logic [1:0]    vld_pipe;
    logic [31:0]   s1_y;
    logic [CW-1:0] s1_chan;
    logic          s1_last;

    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            s1_y    <= '0;
            s1_chan <= '0;
            s1_last <= 1'b0;
        end else if (accept) begin
            s1_y    <= y_in;
            s1_chan <= cnt_q;
            s1_last <= last;
        end
    end

    logic [31:0] s1_key, y_clamp;
    logic        nan1, hi, lo, clamped;

    float_order_key u_key (
        .bits (s1_y),
        .key  (s1_key)
    );

    always_comb begin
        nan1    = is_nan(s1_y);
        hi      = s1_key > KMAX;
        lo      = s1_key < KMIN;
        clamped = !nan1 && (hi || lo);
        y_clamp = s1_y;
        if (nan1)    y_clamp = 32'h00000000;
        else if (hi) y_clamp = YMAX;
        else if (lo) y_clamp = YMIN;
    end

    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            vld_pipe  <= '0;
            y_out     <= '0;
            chan_out  <= '0;
            done_sig  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[0], accept};
            // An abort landing while the last sample is in flight
            // cancels that frame's done pulse.
            done_sig  <= vld_pipe[0] && s1_last && !abort;
            frame_err <= (vld_pipe[0] && nan1) || proto_err;
            if (vld_pipe[0]) begin
                y_out    <= y_clamp;
                chan_out <= s1_chan;
            end
        end
    end

    assign valid_out = vld_pipe[1];

    // ------------------------------------------------------------------
    // Saturation bitmap (optional)
    // ------------------------------------------------------------------
`ifdef PID_LIMIT_STATUS_EN
    logic [N_CH-1:0] sat_q;

    // NaN samples neither clamp nor pass, so they leave the flag alone.
    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            sat_q <= '0;
        end else if (vld_pipe[0] && !nan1) begin
            sat_q[s1_chan] <= clamped;
        end
    end

    assign sat_flags = sat_q;
`else
    assign sat_flags = '0;
`endif

endmodule

// File: tb/tb_pid_output_limiter.sv
// ----------------------------------------------------------------------------
// tb_pid_output_limiter
// Directed bench for pid_output_limiter with N_CH=4. Expected outputs and
// error pulses are queued with the cycle they are due and checked at each
// negedge. Sat-flag expectations follow PID_LIMIT_STATUS_EN.
// ----------------------------------------------------------------------------
module tb_pid_output_limiter;

    localparam int N_CH = 4;
    localparam int CW   = 2;

    localparam logic [31:0] ZERO = 32'h00000000;
    localparam logic [31:0] HALF = 32'h3F000000;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] M3   = 32'hC0400000;
    localparam logic [31:0] P1   = 32'h3F800000;
    localparam logic [31:0] M1   = 32'hBF800000;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] NINF = 32'hFF800000;
    localparam logic [31:0] MHLF = 32'hBF000000;

`ifdef PID_LIMIT_STATUS_EN
    localparam logic [N_CH-1:0] SAT_A = 4'b0100;
`else
    localparam logic [N_CH-1:0] SAT_A = 4'b0000;
`endif

    logic            clk = 1'b0;
    logic            rst_user = 1'b0;
    logic            sta = 1'b0;
    logic            valid_in = 1'b0;
    logic [31:0]     y_in = '0;
    logic [31:0]     y_out;
    logic            valid_out;
    logic [CW-1:0]   chan_out;
    logic            done_sig;
    logic            frame_err;
    logic [N_CH-1:0] sat_flags;

    always #5 clk = ~clk;

    pid_output_limiter #(.N_CH(N_CH)) dut (
        .clk       (clk),
        .rst_user  (rst_user),
        .sta       (sta),
        .valid_in  (valid_in),
        .y_in      (y_in),
        .y_out     (y_out),
        .valid_out (valid_out),
        .chan_out  (chan_out),
        .done_sig  (done_sig),
        .frame_err (frame_err),
        .sat_flags (sat_flags)
    );

    typedef struct {
        int            due;
        logic [31:0]   y;
        logic [CW-1:0] ch;
        logic          dn;
    } exp_t;

    exp_t out_q[$];
    int   err_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare everything the DUT shows this cycle against the queues.
    task automatic monitor();
        exp_t e;
        logic ferr_exp;
        ferr_exp = 1'b0;
        if (out_q.size() > 0 && out_q[0].due <= cyc) begin
            e = out_q.pop_front();
            chk("valid_out", 32'(valid_out), 32'd1);
            chk("y_out",     y_out,          e.y);
            chk("chan_out",  32'(chan_out),  32'(e.ch));
            chk("done_sig",  32'(done_sig),  32'(e.dn));
        end else begin
            chk("valid_out_idle", 32'(valid_out), 32'd0);
            chk("done_sig_idle",  32'(done_sig),  32'd0);
        end
        for (int i = err_q.size() - 1; i >= 0; i--) begin
            if (err_q[i] == cyc) begin
                ferr_exp = 1'b1;
                err_q.delete(i);
            end
        end
        chk("frame_err", 32'(frame_err), 32'(ferr_exp));
    endtask

    task automatic step(input logic s, input logic v, input logic [31:0] y);
        sta      = s;
        valid_in = v;
        y_in     = y;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sta      = 1'b0;
        valid_in = 1'b0;
        y_in     = '0;
        monitor();
    endtask

    task automatic samp(input logic [31:0] y, input logic [31:0] ey,
                        input logic [CW-1:0] ch, input logic dn);
        exp_t e;
        e.due = cyc + 2;
        e.y   = ey;
        e.ch  = ch;
        e.dn  = dn;
        out_q.push_back(e);
        step(1'b0, 1'b1, y);
    endtask

    task automatic err_at(input int lat);
        err_q.push_back(cyc + lat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ZERO);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_y_out"},     y_out,           ZERO);
        chk({tag, "_valid_out"}, 32'(valid_out),  32'd0);
        chk({tag, "_chan_out"},  32'(chan_out),   32'd0);
        chk({tag, "_done_sig"},  32'(done_sig),   32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err),  32'd0);
        chk({tag, "_sat_flags"}, 32'(sat_flags),  32'd0);
    endtask

    initial begin
        // Reset state
        #2 rst_user = 1'b1;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_user = 1'b0;

        // Basic frame: in range, above max, below min, exactly min
        step(1'b1, 1'b0, ZERO);
        samp(HALF, HALF, 2'd0, 1'b0);
        samp(TWO,  P1,   2'd1, 1'b0);
        samp(M3,   M1,   2'd2, 1'b0);
        samp(M1,   M1,   2'd3, 1'b1);
        idle(3);

        // NaN on channel 1: zero output, error with that output, done kept
        step(1'b1, 1'b0, ZERO);
        samp(HALF, HALF, 2'd0, 1'b0);
        err_at(2);
        samp(QNAN, ZERO, 2'd1, 1'b0);
        samp(MHLF, MHLF, 2'd2, 1'b0);
        samp(HALF, HALF, 2'd3, 1'b1);
        idle(3);

        // Abort after two samples, then a full frame with a gap and -Inf
        step(1'b1, 1'b0, ZERO);
        samp(HALF, HALF, 2'd0, 1'b0);
        samp(TWO,  P1,   2'd1, 1'b0);
        err_at(1);
        step(1'b1, 1'b0, ZERO);
        samp(HALF, HALF, 2'd0, 1'b0);
        samp(PINF, P1,   2'd1, 1'b0);
        idle(2);
        samp(NINF, M1,   2'd2, 1'b0);
        samp(ZERO, ZERO, 2'd3, 1'b1);
        idle(3);

        // valid_in while idle is dropped
        err_at(1);
        step(1'b0, 1'b1, HALF);
        idle(2);

        // sta with valid_in in IDLE: sample dropped, frame still starts
        err_at(1);
        step(1'b1, 1'b1, HALF);
        samp(HALF, HALF, 2'd0, 1'b0);
        samp(HALF, HALF, 2'd1, 1'b0);
        samp(HALF, HALF, 2'd2, 1'b0);
        samp(HALF, HALF, 2'd3, 1'b1);
        // valid_in during FLUSH is dropped
        err_at(1);
        step(1'b0, 1'b1, TWO);
        idle(3);

        // sta right after the last sample cancels that frame's done
        step(1'b1, 1'b0, ZERO);
        samp(HALF, HALF, 2'd0, 1'b0);
        samp(HALF, HALF, 2'd1, 1'b0);
        samp(HALF, HALF, 2'd2, 1'b0);
        samp(HALF, HALF, 2'd3, 1'b0);
        err_at(1);
        step(1'b1, 1'b0, ZERO);
        samp(M3,   M1,   2'd0, 1'b0);
        samp(HALF, HALF, 2'd1, 1'b0);
        samp(HALF, HALF, 2'd2, 1'b0);
        samp(HALF, HALF, 2'd3, 1'b1);
        idle(3);

        // Saturation bitmap: only channel 2 clamps, then it passes
        step(1'b1, 1'b0, ZERO);
        samp(ZERO, ZERO, 2'd0, 1'b0);
        samp(ZERO, ZERO, 2'd1, 1'b0);
        samp(PINF, P1,   2'd2, 1'b0);
        samp(ZERO, ZERO, 2'd3, 1'b1);
        idle(3);
        chk("sat_flags_frame1", 32'(sat_flags), 32'(SAT_A));
        step(1'b1, 1'b0, ZERO);
        samp(ZERO, ZERO, 2'd0, 1'b0);
        samp(ZERO, ZERO, 2'd1, 1'b0);
        samp(ZERO, ZERO, 2'd2, 1'b0);
        samp(ZERO, ZERO, 2'd3, 1'b1);
        idle(3);
        chk("sat_flags_frame2", 32'(sat_flags), 32'd0);

        // Reset while channel 2 is being accepted
        step(1'b1, 1'b0, ZERO);
        samp(HALF, HALF, 2'd0, 1'b0);
        samp(TWO,  P1,   2'd1, 1'b0);
        valid_in = 1'b1;
        y_in     = HALF;
        @(posedge clk);
        cyc++;
        #2 rst_user = 1'b1;
        #1 chk_all_zero("midframe_reset");
        out_q.delete();
        err_q.delete();
        valid_in = 1'b0;
        y_in     = '0;
        @(negedge clk);
        rst_user = 1'b0;
        idle(4);
        step(1'b1, 1'b0, ZERO);
        samp(HALF, HALF, 2'd0, 1'b0);
        samp(HALF, HALF, 2'd1, 1'b0);
        samp(TWO,  P1,   2'd2, 1'b0);
        samp(HALF, HALF, 2'd3, 1'b1);
        idle(3);

        chk("out_queue_drained", 32'(out_q.size()), 32'd0);
        chk("err_queue_drained", 32'(err_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_output_limiter.md
PID_OUTPUT_LIMITER -- requirements
Module: pid_output_limiter

Interface
REQ-001 Parameter N_CH, default `N_WindTurbine: channels per frame, range 2..1024.
REQ-002 Parameter YMAX, default 32'h3F800000 (+1.0): IEEE-754 single upper clamp.
REQ-003 Parameter YMIN, default 32'hBF800000 (-1.0): IEEE-754 single lower clamp; YMIN SHALL be less than YMAX.
REQ-004 The block SHALL use clock clk and reset rst_user (asynchronous, active-high).
REQ-005 Ports SHALL be, one per line:
- clk  in  1  clock
- rst_user  in  1  async active-high reset
- sta  in  1  frame-start strobe, one cycle
- valid_in  in  1  y_in valid
- y_in  in  32  PID output sample, single float
- y_out  out  32  clamped sample
- valid_out  out  1  y_out valid
- chan_out  out  clog2(N_CH)  channel index of y_out
- done_sig  out  1  one-cycle end-of-frame pulse
- frame_err  out  1  one-cycle protocol-error pulse
- sat_flags  out  N_CH  per-channel saturation bitmap (see Configuration)

Function
REQ-006 FSM states SHALL be IDLE, RUN, FLUSH; reset state IDLE.
REQ-007 IDLE->RUN on sta; channel counter cleared to 0.
REQ-008 In RUN, each valid_in cycle SHALL accept one sample and increment the channel counter; the counter SHALL NOT wrap within a frame.
REQ-009 RUN->FLUSH after sample N_CH-1 is accepted; FLUSH->IDLE after 2 cycles, with done_sig pulsing on the cycle valid_out carries channel N_CH-1.
REQ-010 Latency SHALL be exactly 2 cycles from valid_in to valid_out; throughput one sample per cycle; gaps in valid_in allowed.
REQ-011 Comparison SHALL use an ordered key: key = sign ? ~bits : bits|32'h80000000; compare keys unsigned.
REQ-012 key(y_in) > key(YMAX) -> y_out = YMAX; key(y_in) < key(YMIN) -> y_out = YMIN; otherwise y_out = y_in bit-exact.
REQ-013 NaN input (exp all ones, mantissa nonzero) SHALL output 32'h00000000 and pulse frame_err; +/-Inf SHALL clamp normally.
REQ-014 valid_in in IDLE or FLUSH SHALL be dropped and pulse frame_err.
REQ-015 sta in RUN or FLUSH SHALL abort the frame: pulse frame_err, suppress done_sig, and restart RUN at channel 0; in-flight pipeline samples still emerge with their original chan_out.
REQ-016 sta coincident with valid_in in IDLE: the sample SHALL be dropped and frame_err pulsed.

Reset
REQ-017 On rst_user: state IDLE, counter 0, y_out 0, valid_out 0, chan_out 0, done_sig 0, frame_err 0, sat_flags all 0, pipeline valids cleared.
REQ-018 Reset mid-frame SHALL discard all in-flight samples with no partial done_sig.

Configuration
REQ-019 Macro PID_LIMIT_STATUS_EN defined: sat_flags[c] is set when channel c's sample clamps (REQ-012) and cleared when it passes unclamped; updated with valid_out; it holds across frames.
REQ-020 Macro undefined: sat_flags is tied to 0 and no flag storage is synthesised; all other behaviour is unchanged.

Structure
REQ-021 Shared package/include SHALL hold the float key function, the NaN-detect function, and the FSM state encodings; `SINGLE comes from global_parameter.v.
REQ-022 One sub-module, float_order_key (combinational 32-bit key), SHALL be instantiated three times or once with constant keys precomputed.

Verification
REQ-023 N_CH=4; sta, then y_in = 0.5, 2.0, -3.0, -1.0 -> y_out = 3F000000, 3F800000, BF800000, BF800000; chan 0..3; done_sig with chan 3.
REQ-024 NaN 7FC00000 on chan 1 -> y_out 00000000, frame_err pulse on that cycle's output, done_sig still asserted.
REQ-025 sta after 2 of 4 samples -> frame_err pulse, no done_sig; next 4 samples produce chan 0..3 and done_sig.
REQ-026 valid_in while IDLE with y_in 3F000000 -> no valid_out, frame_err pulse.
REQ-027 rst_user asserted during chan 2 -> all outputs 0 asynchronously; no done_sig after release until a new full frame.
REQ-028 With PID_LIMIT_STATUS_EN: frame 1 clamps chan 2 -> sat_flags=4'b0100; frame 2 chan 2 = 0.0 -> 4'b0000; without the macro sat_flags stays 0.
